midi_msg_parser: RTL and testbench
==================================

// Module: midi_msg_parser
// PURPOSE
//  Byte-to-message MIDI parser. Sits between midi_receiver (byte + valid) and downstream consumers (display, synth voice logic).
//  Assembles channel-voice messages with running status, skips SysEx and system common, optionally forwards realtime bytes.
//  Filters by channel and emits one complete message per msg_valid pulse.
// PARAMETERS
//  CHANNEL_MASK     16'hFFFF  bit n=1 accepts MIDI channel n (status[3:0]==n)
//  ACCEPT_REALTIME  1'b0      1: forward 0xF8-0xFF as 1-byte messages; 0: drop silently
//  VEL0_AS_OFF      1'b1      1: Note On (0x9n) with data2==0 is reported as Note Off 0x8n
// PORTS
//  clk          in   1  system clock
//  reset        in   1  synchronous, active-high reset
//  byte_in      in   8  received MIDI byte
//  byte_valid   in   1  byte_in valid this cycle (single-cycle strobe, no backpressure)
//  msg_status   out  8  status byte of the last emitted message
//  msg_data1    out  7  first data byte (0 when msg_len<1)
//  msg_data2    out  7  second data byte (0 when msg_len<2)
//  msg_len      out  2  number of data bytes in the message: 0, 1 or 2
//  msg_valid    out  1  one-cycle pulse; the msg_* fields are new this cycle
//  err_pulse    out  1  one-cycle pulse on a protocol error (see below)
// BEHAVIOUR
//  - Reset: every output is 0; state=IDLE; running status cleared; data counter cleared. Reset mid-message discards the partial message.
//  - States:
//    - IDLE: no running status.
//    - WAIT_D1 / WAIT_D2: running status held; waiting for data byte 1 / 2.
//    - SYSEX: discarding bytes.
//  - Data length by status[7:4]:
//    - 8,9,A,B,E -> 2 bytes.
//    - C,D -> 1 byte.
//  - Status 0x80-0xEF (any state except SYSEX):
//    - Latch it as running status, then go to WAIT_D1.
//    - If it arrives in WAIT_D2, or in WAIT_D1 after data1 of a 2-byte message, the partial message is dropped and err_pulse=1.
//  - Data byte (bit7=0):
//    - WAIT_D1, 1-byte message: emit, stay WAIT_D1 (running status).
//    - WAIT_D1, 2-byte message: store data1, go to WAIT_D2.
//    - WAIT_D2: emit, go back to WAIT_D1.
//    - IDLE: drop the byte and pulse err_pulse.
//    - SYSEX: ignore.
//  - 0xF0: clear running status, go to SYSEX. In SYSEX, every byte except 0xF7 and realtime bytes is ignored.
//    0xF7 in SYSEX goes to IDLE. 0xF7 outside SYSEX is ignored.
//  - 0xF1-0xF6: clear running status, go to IDLE. Their data bytes then land in IDLE and raise err_pulse (accepted behaviour).
//  - 0xF8-0xFF realtime: never change state, running status or stored data1; legal in every state, including mid-message and SYSEX.
//    With ACCEPT_REALTIME=1: emit status=byte, len=0, data=0.
//  - Latency: msg_valid and the msg_* fields update exactly 1 cycle after the byte_valid of the completing byte.
//    msg_* fields hold their values until the next emission. err_pulse has the same 1-cycle latency.
//  - Channel filter: a completed message whose CHANNEL_MASK[status[3:0]] is 0 is not emitted (no msg_valid, no err_pulse).
//    Parser state advances exactly as if it had been emitted. The filter does not apply to realtime bytes.
//  - VEL0_AS_OFF conversion applies only to the emitted status; the stored running status stays 0x9n.
//  - Back-to-back byte_valid on consecutive cycles is supported at full rate; every byte is consumed in its arrival cycle.
// STRUCTURE
//  - midi_pkg (shared package):
//    - status-nibble constants (ST_NOTE_OFF=4'h8 .. ST_PITCH=4'hE), SYSEX_START=8'hF0, SYSEX_END=8'hF7, RT_MIN=8'hF8
//    - parser_state_t enum {IDLE, WAIT_D1, WAIT_D2, SYSEX}
//    - function midi_data_len(logic [7:0] status) -> logic [1:0]
//  - No sub-module. Single FSM plus holding registers.
//  - The next midi_top revision instantiates it between midi_receiver and led_dec.
// TESTING (defaults unless stated; bytes are on consecutive byte_valid cycles)
//  - 90 3C 64 -> one msg_valid: status 90, d1 3C, d2 64, len 2, exactly 1 cycle after the 0x64 strobe; no err_pulse.
//  - 90 3C 64 40 00 -> two messages. The second is status 80, d1 40, d2 00 (running status + vel0 conversion).
//    Repeat with VEL0_AS_OFF=0 -> status 90.
//  - ACCEPT_REALTIME=1, 90 3C F8 64 -> realtime message status F8 len 0, then note 90/3C/64.
//    ACCEPT_REALTIME=0 -> only the note.
//  - F0 01 02 F7 3C -> no msg_valid during SysEx; the 0x3C afterwards gives err_pulse=1 (running status cleared).
//  - CHANNEL_MASK=16'h0001: 91 3C 64 -> no msg_valid. Then 90 3C 64 -> emitted.
//    Also C5 07 with mask FFFF -> status C5, d1 07, d2 00, len 1.
//  - 90 3C, reset for 1 cycle, 64 -> no msg_valid; err_pulse=1 on the 0x64; all outputs 0 after the reset.

Source files
------------

// File: rtl/midi_pkg.sv
// Shared MIDI definitions: status nibbles, framing bytes, parser states and
// the data-length lookup used by the message parser.
package midi_pkg;

    localparam logic [3:0] ST_NOTE_OFF = 4'h8;
    localparam logic [3:0] ST_NOTE_ON  = 4'h9;
    localparam logic [3:0] ST_POLY_AT  = 4'hA;
    localparam logic [3:0] ST_CTRL     = 4'hB;
    localparam logic [3:0] ST_PROGRAM  = 4'hC;
    localparam logic [3:0] ST_CHAN_AT  = 4'hD;
    localparam logic [3:0] ST_PITCH    = 4'hE;

    localparam logic [7:0] SYSEX_START = 8'hF0;
    localparam logic [7:0] SYSEX_END   = 8'hF7;
    localparam logic [7:0] RT_MIN      = 8'hF8;
    localparam logic [7:0] SYS_MIN     = 8'hF0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_D1 = 2'd1,
        WAIT_D2 = 2'd2,
        SYSEX   = 2'd3
    } parser_state_t;

    // Number of data bytes that follow a channel-voice status byte.
    // Non channel-voice statuses report 0.
    function automatic logic [1:0] midi_data_len(input logic [7:0] status);
        logic [1:0] len;
        case (status[7:4])
            ST_NOTE_OFF, ST_NOTE_ON, ST_POLY_AT, ST_CTRL, ST_PITCH: len = 2'd2;
            ST_PROGRAM, ST_CHAN_AT:                                 len = 2'd1;
            default:                                                len = 2'd0;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/midi_msg_parser.sv
// Byte-to-message MIDI parser: assembles channel-voice messages with running
// status, discards SysEx and system common traffic, optionally forwards
// realtime bytes, filters by channel and emits one message per msg_valid.
module midi_msg_parser
    import midi_pkg::*;
#(
    parameter logic [15:0] CHANNEL_MASK    = 16'hFFFF,
    parameter logic        ACCEPT_REALTIME = 1'b0,
    parameter logic        VEL0_AS_OFF     = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] byte_in,
    input  logic       byte_valid,
    output logic [7:0] msg_status,
    output logic [6:0] msg_data1,
    output logic [6:0] msg_data2,
    output logic [1:0] msg_len,
    output logic       msg_valid,
    output logic       err_pulse
);

    parser_state_t state_q, state_d;
    logic [7:0]    rs_q, rs_d;          // running status, 0 when none
    logic [6:0]    d1_q, d1_d;          // stored first data byte

    logic [7:0]    msg_status_q, msg_status_d;
    logic [6:0]    msg_data1_q, msg_data1_d;
    logic [6:0]    msg_data2_q, msg_data2_d;
    logic [1:0]    msg_len_q, msg_len_d;
    logic          msg_valid_q, msg_valid_d;
    logic          err_q, err_d;

    logic          ch_accept_s;
    logic          vel0_off_s;

    // Channel filter and velocity-zero detection for the message being completed.
    always_comb begin
        ch_accept_s = CHANNEL_MASK[rs_q[3:0]];
        if (VEL0_AS_OFF && (rs_q[7:4] == ST_NOTE_ON) && (byte_in[6:0] == 7'd0)) begin
            vel0_off_s = 1'b1;
        end else begin
            vel0_off_s = 1'b0;
        end
    end

    // Next-state, running-status and emission decode for the incoming byte.
    always_comb begin
        state_d      = state_q;
        rs_d         = rs_q;
        d1_d         = d1_q;
        msg_status_d = msg_status_q;
        msg_data1_d  = msg_data1_q;
        msg_data2_d  = msg_data2_q;
        msg_len_d    = msg_len_q;
        msg_valid_d  = 1'b0;
        err_d        = 1'b0;

        if (!byte_valid) begin
            state_d = state_q;
        end else if (byte_in >= RT_MIN) begin
            // Realtime is transparent to the parse in every state.
            if (ACCEPT_REALTIME) begin
                msg_status_d = byte_in;
                msg_data1_d  = 7'd0;
                msg_data2_d  = 7'd0;
                msg_len_d    = 2'd0;
                msg_valid_d  = 1'b1;
            end else begin
                msg_valid_d  = 1'b0;
            end
        end else if (state_q == SYSEX) begin
            if (byte_in == SYSEX_END) begin
                state_d = IDLE;
            end else begin
                state_d = SYSEX;
            end
        end else if (byte_in[7] == 1'b0) begin
            case (state_q)
                WAIT_D1: begin
                    if (midi_data_len(rs_q) == 2'd1) begin
                        msg_status_d = rs_q;
                        msg_data1_d  = byte_in[6:0];
                        msg_data2_d  = 7'd0;
                        msg_len_d    = 2'd1;
                        msg_valid_d  = ch_accept_s;
                        state_d      = WAIT_D1;
                    end else begin
                        d1_d         = byte_in[6:0];
                        state_d      = WAIT_D2;
                    end
                end
                WAIT_D2: begin
                    if (vel0_off_s) begin
                        msg_status_d = {ST_NOTE_OFF, rs_q[3:0]};
                    end else begin
                        msg_status_d = rs_q;
                    end
                    msg_data1_d  = d1_q;
                    msg_data2_d  = byte_in[6:0];
                    msg_len_d    = 2'd2;
                    msg_valid_d  = ch_accept_s;
                    state_d      = WAIT_D1;
                end
                IDLE: begin
                    err_d = 1'b1;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
            // A filtered message must not leave the held fields changed.
            if (!msg_valid_d) begin
                msg_status_d = msg_status_q;
                msg_data1_d  = msg_data1_q;
                msg_data2_d  = msg_data2_q;
                msg_len_d    = msg_len_q;
            end else begin
                msg_len_d    = msg_len_d;
            end
        end else if (byte_in < SYS_MIN) begin
            // New channel status; a half-built 2-byte message is abandoned.
            if (state_q == WAIT_D2) begin
                err_d = 1'b1;
            end else begin
                err_d = 1'b0;
            end
            rs_d    = byte_in;
            state_d = WAIT_D1;
        end else if (byte_in == SYSEX_START) begin
            rs_d    = 8'h00;
            state_d = SYSEX;
        end else if (byte_in == SYSEX_END) begin
            state_d = state_q;
        end else begin
            // System common F1-F6 cancels running status.
            rs_d    = 8'h00;
            state_d = IDLE;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            rs_q         <= 8'h00;
            d1_q         <= 7'd0;
            msg_status_q <= 8'h00;
            msg_data1_q  <= 7'd0;
            msg_data2_q  <= 7'd0;
            msg_len_q    <= 2'd0;
            msg_valid_q  <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            rs_q         <= rs_d;
            d1_q         <= d1_d;
            msg_status_q <= msg_status_d;
            msg_data1_q  <= msg_data1_d;
            msg_data2_q  <= msg_data2_d;
            msg_len_q    <= msg_len_d;
            msg_valid_q  <= msg_valid_d;
            err_q        <= err_d;
        end
    end

    assign msg_status = msg_status_q;
    assign msg_data1  = msg_data1_q;
    assign msg_data2  = msg_data2_q;
    assign msg_len    = msg_len_q;
    assign msg_valid  = msg_valid_q;
    assign err_pulse  = err_q;

endmodule

// File: tb/tb_midi_msg_parser.sv
// Bench for midi_msg_parser: four parameterisations share one byte stream,
// each compared every cycle against a message-level reference model.
module tb_midi_msg_parser;

    localparam int NCFG = 4;
    // cfg0 defaults, cfg1 VEL0_AS_OFF=0, cfg2 ACCEPT_REALTIME=1, cfg3 mask 0001
    localparam logic [63:0] MASKS = {16'h0001, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    localparam logic [3:0]  RTS   = 4'b0100;
    localparam logic [3:0]  VEL0S = 4'b1101;

    logic       clk;
    logic       reset;
    logic [7:0] byte_in;
    logic       byte_valid;

    logic [7:0] o_status [NCFG];
    logic [6:0] o_d1     [NCFG];
    logic [6:0] o_d2     [NCFG];
    logic [1:0] o_len    [NCFG];
    logic       o_valid  [NCFG];
    logic       o_err    [NCFG];

    int checks;
    int errors;

    // reference model state, per configuration
    logic [7:0] m_rs    [NCFG];
    bit         m_sysex [NCFG];
    bit         m_have  [NCFG];
    logic [6:0] m_d1    [NCFG];
    logic [7:0] e_status[NCFG];
    logic [6:0] e_d1    [NCFG];
    logic [6:0] e_d2    [NCFG];
    logic [1:0] e_len   [NCFG];
    logic       e_valid [NCFG];
    logic       e_err   [NCFG];

    for (genvar g = 0; g < NCFG; g++) begin : g_dut
        midi_msg_parser #(
            .CHANNEL_MASK   (MASKS[g*16 +: 16]),
            .ACCEPT_REALTIME(RTS[g]),
            .VEL0_AS_OFF    (VEL0S[g])
        ) u_dut (
            .clk       (clk),
            .reset     (reset),
            .byte_in   (byte_in),
            .byte_valid(byte_valid),
            .msg_status(o_status[g]),
            .msg_data1 (o_d1[g]),
            .msg_data2 (o_d2[g]),
            .msg_len   (o_len[g]),
            .msg_valid (o_valid[g]),
            .err_pulse (o_err[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic emit(input int c, input logic [7:0] st, input logic [6:0] a,
                        input logic [6:0] b, input logic [1:0] len);
        e_valid[c]  = 1'b1;
        e_status[c] = st;
        e_d1[c]     = a;
        e_d2[c]     = b;
        e_len[c]    = len;
    endtask

    task automatic complete(input int c, input logic [6:0] a, input logic [6:0] b,
                            input logic [1:0] len);
        logic [7:0]  st;
        logic [15:0] mask;
        st   = m_rs[c];
        mask = MASKS[c*16 +: 16];
        if (VEL0S[c] && len == 2'd2 && st[7:4] == 4'h9 && b == 7'd0)
            st = {4'h8, m_rs[c][3:0]};
        if (mask[m_rs[c][3:0]])
            emit(c, st, a, b, len);
    endtask

    // Expected outputs after one clock carrying (rst, v, b).
    task automatic model(input int c, input bit rst, input bit v, input logic [7:0] b);
        int need;
        e_valid[c] = 1'b0;
        e_err[c]   = 1'b0;
        if (rst) begin
            m_rs[c] = 8'h00; m_sysex[c] = 1'b0; m_have[c] = 1'b0; m_d1[c] = 7'd0;
            e_status[c] = 8'h00; e_d1[c] = 7'd0; e_d2[c] = 7'd0; e_len[c] = 2'd0;
        end else if (v) begin
            if (b >= 8'hF8) begin
                if (RTS[c]) emit(c, b, 7'd0, 7'd0, 2'd0);
            end else if (m_sysex[c]) begin
                if (b == 8'hF7) m_sysex[c] = 1'b0;
            end else if (b < 8'h80) begin
                if (m_rs[c] == 8'h00) begin
                    e_err[c] = 1'b1;
                end else begin
                    need = (m_rs[c][7:4] == 4'hC || m_rs[c][7:4] == 4'hD) ? 1 : 2;
                    if (need == 1) begin
                        complete(c, b[6:0], 7'd0, 2'd1);
                    end else if (!m_have[c]) begin
                        m_have[c] = 1'b1;
                        m_d1[c]   = b[6:0];
                    end else begin
                        m_have[c] = 1'b0;
                        complete(c, m_d1[c], b[6:0], 2'd2);
                    end
                end
            end else if (b < 8'hF0) begin
                if (m_have[c]) e_err[c] = 1'b1;
                m_rs[c]   = b;
                m_have[c] = 1'b0;
            end else if (b == 8'hF0) begin
                m_rs[c] = 8'h00; m_have[c] = 1'b0; m_sysex[c] = 1'b1;
            end else if (b != 8'hF7) begin
                m_rs[c] = 8'h00; m_have[c] = 1'b0;
            end
        end
    endtask

    task automatic check(input int c, input string tag);
        checks++;
        assert (o_valid[c] === e_valid[c]) else begin
            errors++;
            $error("FAIL %s cfg%0d valid got %b want %b", tag, c, o_valid[c], e_valid[c]);
        end
        checks++;
        assert (o_err[c] === e_err[c]) else begin
            errors++;
            $error("FAIL %s cfg%0d err got %b want %b", tag, c, o_err[c], e_err[c]);
        end
        checks++;
        assert ({o_status[c], o_d1[c], o_d2[c], o_len[c]} ===
                {e_status[c], e_d1[c], e_d2[c], e_len[c]}) else begin
            errors++;
            $error("FAIL %s cfg%0d fields got %h/%h/%h/%0d want %h/%h/%h/%0d", tag, c,
                   o_status[c], o_d1[c], o_d2[c], o_len[c],
                   e_status[c], e_d1[c], e_d2[c], e_len[c]);
        end
    endtask

    // Apply one cycle of stimulus, then compare all configurations.
    task automatic step(input bit rst, input bit v, input logic [7:0] b, input string tag);
        @(negedge clk);
        reset      = rst;
        byte_valid = v;
        byte_in    = b;
        for (int c = 0; c < NCFG; c++) model(c, rst, v, b);
        @(posedge clk);
        #1;
        for (int c = 0; c < NCFG; c++) check(c, tag);
    endtask

    task automatic send(input logic [7:0] b, input string tag);
        step(1'b0, 1'b1, b, tag);
    endtask

    function automatic logic [7:0] rand_byte();
        int r;
        r = $urandom_range(0, 99);
        if (r < 50)      return {1'b0, 7'($urandom_range(0, 127))};
        else if (r < 75) return 8'($urandom_range(128, 239));
        else if (r < 80) return 8'hF0;
        else if (r < 86) return 8'hF7;
        else if (r < 90) return 8'($urandom_range(241, 246));
        else             return 8'($urandom_range(248, 255));
    endfunction

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1; byte_valid = 1'b0; byte_in = 8'h00;
        step(1'b1, 1'b0, 8'h00, "reset");
        step(1'b1, 1'b1, 8'h90, "reset_hold");
        step(1'b0, 1'b0, 8'h00, "idle");
        // note on, then running status with velocity zero
        send(8'h90, "n_st"); send(8'h3C, "n_d1"); send(8'h64, "n_d2");
        step(1'b0, 1'b0, 8'h00, "n_after");
        send(8'h40, "rs_d1"); send(8'h00, "rs_vel0");
        // realtime in the middle of a note
        send(8'h90, "rt_st"); send(8'h3C, "rt_d1"); send(8'hF8, "rt_clk"); send(8'h64, "rt_d2");
        // sysex then stray data
        send(8'hF0, "sx_start"); send(8'h01, "sx_b1"); send(8'h02, "sx_b2");
        send(8'hF7, "sx_end"); send(8'h3C, "sx_stray");
        // channel filter
        send(8'h91, "f_st"); send(8'h3C, "f_d1"); send(8'h64, "f_d2");
        send(8'h90, "f0_st"); send(8'h3C, "f0_d1"); send(8'h64, "f0_d2");
        // program change, one data byte
        send(8'hC5, "pc_st"); send(8'h07, "pc_d1"); send(8'h09, "pc_rs");
        // status interrupting a half-built message
        send(8'h90, "int_st"); send(8'h3C, "int_d1"); send(8'hB0, "int_new");
        send(8'h07, "int_d1b"); send(8'h7F, "int_d2b");
        // reset mid-message
        send(8'h90, "rm_st"); send(8'h3C, "rm_d1");
        step(1'b1, 1'b0, 8'h00, "rm_reset");
        send(8'h64, "rm_stray");
        // system common cancels running status
        send(8'hE0, "sc_st"); send(8'hF3, "sc_sys"); send(8'h10, "sc_stray");
        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0)
                step(1'b1, 1'($urandom_range(0, 1)), rand_byte(), "rnd_reset");
            else
                step(1'b0, ($urandom_range(0, 9) < 8), rand_byte(), "rnd");
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
